// File: rtl/tank_pkg.sv
// -----------------------------------------------------------------------------
// tank_pkg
// Shared types and constants for the tank movement scheduler slice.
//   - dir_e    : tank facing / move direction (up, down, left, right)
//   - state_e  : scheduler FSM states
//   - grid geometry, coordinate width, tank footprint
//   - reset_x(): spawn column of tank i
// No ports (package).
// -----------------------------------------------------------------------------
package tank_pkg;

    localparam int GRID_W     = 64;   // playfield width in cells
    localparam int GRID_H     = 48;   // playfield height in cells
    localparam int CELL_PX    = 10;   // pixels per cell edge
    localparam int COORD_W    = 6;    // bits per cell coordinate
    localparam int TANK_SZ    = 3;    // square footprint in cells
    localparam int N_TANK_DEF = 5;    // default tank count (index 0 = player)
    localparam int SPAWN_Y    = 22;   // common spawn row

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_COMMIT,
        ST_DONE
    } state_e;

    // Tanks spawn spread across the field, 12 cells apart.
    function automatic logic [COORD_W-1:0] reset_x(input int i);
        return COORD_W'(2 + 12 * i);
    endfunction

endpackage

// File: rtl/tank_move_scheduler_if.sv
// -----------------------------------------------------------------------------
// tank_move_scheduler_if
// Bundles the scheduler's frame-level request inputs and renderer outputs.
//   master (game logic / renderer side): drives frame_tick, tank_alive,
//          move_req, move_dir; observes positions, facing and status.
//   slave  (scheduler): the reverse.
// Signals:
//   frame_tick  1-cycle pulse at start of vertical blanking
//   tank_alive  per-tank alive flag
//   move_req    per-tank move request level
//   move_dir    per-tank requested direction, 2 bits each
//   tank_x/y    packed cell position, tank i at [6i+5:6i]
//   tank_dir    packed facing direction
//   busy, upd_done, overrun  status
// -----------------------------------------------------------------------------
interface tank_move_scheduler_if
    import tank_pkg::*;
#(
    parameter int N_TANK = N_TANK_DEF
);
    logic                        frame_tick;
    logic [N_TANK-1:0]           tank_alive;
    logic [N_TANK-1:0]           move_req;
    logic [2*N_TANK-1:0]         move_dir;
    logic [COORD_W*N_TANK-1:0]   tank_x;
    logic [COORD_W*N_TANK-1:0]   tank_y;
    logic [2*N_TANK-1:0]         tank_dir;
    logic                        busy;
    logic                        upd_done;
    logic                        overrun;

    modport master (
        output frame_tick, tank_alive, move_req, move_dir,
        input  tank_x, tank_y, tank_dir, busy, upd_done, overrun
    );

    modport slave (
        input  frame_tick, tank_alive, move_req, move_dir,
        output tank_x, tank_y, tank_dir, busy, upd_done, overrun
    );
endinterface

// File: rtl/tank_overlap_cmp.sv
// -----------------------------------------------------------------------------
// tank_overlap_cmp
// Combinational footprint-overlap test between a candidate position and one
// other tank: |dx| < TANK_SZ and |dy| < TANK_SZ, masked when the other tank
// is dead or is the tank being moved.
// Ports:
//   i_cand_x/y  candidate top-left cell of the moving tank
//   i_x/i_y     current top-left cell of the other tank
//   i_alive     other tank is alive
//   i_self      other tank is the moving tank itself
//   o_overlap   footprints would intersect
// -----------------------------------------------------------------------------
module tank_overlap_cmp
    import tank_pkg::*;
(
    input  logic [COORD_W-1:0] i_cand_x,
    input  logic [COORD_W-1:0] i_cand_y,
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    input  logic               i_alive,
    input  logic               i_self,
    output logic               o_overlap
);
    localparam logic signed [COORD_W:0] SZ = (COORD_W+1)'(TANK_SZ);

    // One extra bit keeps the difference of two unsigned coordinates exact.
    logic signed [COORD_W:0] w_dx, w_dy, w_adx, w_ady;

    assign w_dx  = $signed({1'b0, i_cand_x}) - $signed({1'b0, i_x});
    assign w_dy  = $signed({1'b0, i_cand_y}) - $signed({1'b0, i_y});
    assign w_adx = w_dx[COORD_W] ? -w_dx : w_dx;
    assign w_ady = w_dy[COORD_W] ? -w_dy : w_dy;

    assign o_overlap = i_alive && !i_self && (w_adx < SZ) && (w_ady < SZ);
endmodule

// File: rtl/tank_move_scheduler.sv
// -----------------------------------------------------------------------------
// tank_move_scheduler
// Per-frame movement sequencer. On frame_tick it latches every tank's move
// request, then services tanks one at a time in index order: update facing,
// clamp to the playfield, optionally test against every other tank, commit.
// Owns the packed position/facing registers read by the pixel renderer.
// Optional feature macro: TANK_COLLISION_EN
//   defined   : LOAD -> CHECK (N_TANK cycles) -> COMMIT, tank-to-tank blocking
//   undefined : LOAD -> COMMIT, bounds clamping only
// Ports:
//   clk_25m  pixel clock
//   rst_n    asynchronous active-low reset
//   bus      tank_move_scheduler_if.slave (requests in, positions/status out)
// -----------------------------------------------------------------------------
module tank_move_scheduler
    import tank_pkg::*;
#(
    parameter int N_TANK = N_TANK_DEF
)(
    input  logic                  clk_25m,
    input  logic                  rst_n,
    tank_move_scheduler_if.slave  bus
);
    localparam int IDX_W = (N_TANK > 1) ? $clog2(N_TANK) : 1;
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(N_TANK - 1);
    localparam logic signed [COORD_W:0] ONE      = (COORD_W+1)'(1);
    localparam logic signed [COORD_W:0] X_MAX    = (COORD_W+1)'(GRID_W - TANK_SZ);
    localparam logic signed [COORD_W:0] Y_MAX    = (COORD_W+1)'(GRID_H - TANK_SZ);

    state_e               r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [N_TANK-1:0]    r_req;
    logic [N_TANK-1:0]    r_alive;
    logic [1:0]           r_ldir [N_TANK];
    logic [COORD_W-1:0]   r_x    [N_TANK];
    logic [COORD_W-1:0]   r_y    [N_TANK];
    logic [1:0]           r_tdir [N_TANK];
    logic [COORD_W-1:0]   r_cand_x, r_cand_y;
    logic                 r_blocked;
    logic                 r_busy, r_upd_done, r_overrun;

    dir_e                    w_dir;
    logic signed [COORD_W:0] w_cand_x, w_cand_y;
    logic                    w_skip, w_in_bounds, w_advance;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_dir    = dir_e'(r_ldir[r_idx]);
        w_cand_x = $signed({1'b0, r_x[r_idx]});
        w_cand_y = $signed({1'b0, r_y[r_idx]});
        case (w_dir)
            DIR_UP:    w_cand_y = w_cand_y - ONE;
            DIR_DOWN:  w_cand_y = w_cand_y + ONE;
            DIR_LEFT:  w_cand_x = w_cand_x - ONE;
            DIR_RIGHT: w_cand_x = w_cand_x + ONE;
        endcase
        // Bounds are checked on the 7-bit signed value, before truncation.
        w_in_bounds = !w_cand_x[COORD_W] && (w_cand_x <= X_MAX) &&
                      !w_cand_y[COORD_W] && (w_cand_y <= Y_MAX);
        w_skip      = !r_alive[r_idx] || !r_req[r_idx];
        w_advance   = ((r_state == ST_LOAD) && (w_skip || !w_in_bounds)) ||
                      (r_state == ST_COMMIT);
    end

`ifdef TANK_COLLISION_EN
    logic [IDX_W-1:0] r_j;
    logic             w_overlap;

    // Compares against live registers, so lower indices already moved.
    tank_overlap_cmp u_overlap (
        .i_cand_x  (r_cand_x),
        .i_cand_y  (r_cand_y),
        .i_x       (r_x[r_j]),
        .i_y       (r_y[r_j]),
        .i_alive   (r_alive[r_j]),
        .i_self    (r_j == r_idx),
        .o_overlap (w_overlap)
    );
`endif

    // NOTE: the position/facing arrays are architectural state seen by the
    // renderer, so they are reset element by element (small register arrays,
    // not a RAM).
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_req      <= '0;
            r_alive    <= '0;
            r_cand_x   <= '0;
            r_cand_y   <= '0;
            r_blocked  <= 1'b0;
            r_busy     <= 1'b0;
            r_upd_done <= 1'b0;
            r_overrun  <= 1'b0;
`ifdef TANK_COLLISION_EN
            r_j        <= '0;
`endif
            for (int i = 0; i < N_TANK; i++) begin
                r_ldir[i] <= 2'd0;
                r_x[i]    <= reset_x(i);
                r_y[i]    <= COORD_W'(SPAWN_Y);
                r_tdir[i] <= DIR_UP;
            end
        end else begin
            r_upd_done <= 1'b0;
            // Any tick outside IDLE (including DONE) is dropped and flagged.
            r_overrun  <= bus.frame_tick && (r_state != ST_IDLE);

            case (r_state)
                ST_IDLE: begin
                    if (bus.frame_tick) begin
                        r_req   <= bus.move_req;
                        r_alive <= bus.tank_alive;
                        for (int i = 0; i < N_TANK; i++)
                            r_ldir[i] <= bus.move_dir[2*i +: 2];
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!w_skip) begin
                        // Facing follows the request even when the move is clamped.
                        r_tdir[r_idx] <= w_dir;
                        if (w_in_bounds) begin
                            r_cand_x  <= w_cand_x[COORD_W-1:0];
                            r_cand_y  <= w_cand_y[COORD_W-1:0];
                            r_blocked <= 1'b0;
`ifdef TANK_COLLISION_EN
                            r_j       <= '0;
                            r_state   <= ST_CHECK;
`else
                            r_state   <= ST_COMMIT;
`endif
                        end
                    end
                end
`ifdef TANK_COLLISION_EN
                ST_CHECK: begin
                    if (w_overlap)
                        r_blocked <= 1'b1;
                    if (r_j == LAST_IDX)
                        r_state <= ST_COMMIT;
                    else
                        r_j <= r_j + 1'b1;
                end
`endif
                ST_COMMIT: begin
                    if (!r_blocked) begin
                        r_x[r_idx] <= r_cand_x;
                        r_y[r_idx] <= r_cand_y;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase

            // Shared "next tank" step; overrides the state chosen above.
            if (w_advance) begin
                if (r_idx == LAST_IDX) begin
                    r_state    <= ST_DONE;
                    r_busy     <= 1'b0;
                    r_upd_done <= 1'b1;
                end else begin
                    r_idx   <= r_idx + 1'b1;
                    r_state <= ST_LOAD;
                end
            end
        end
    end

    for (genvar g = 0; g < N_TANK; g++) begin : g_pack
        assign bus.tank_x[COORD_W*g +: COORD_W] = r_x[g];
        assign bus.tank_y[COORD_W*g +: COORD_W] = r_y[g];
        assign bus.tank_dir[2*g +: 2]           = r_tdir[g];
    end

    assign bus.busy     = r_busy;
    assign bus.upd_done = r_upd_done;
    assign bus.overrun  = r_overrun;
endmodule

// File: tb/tb_tank_move_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tank_move_scheduler
// Scoreboard bench: each issued frame pushes the expected final positions,
// facings and latency; a monitor pops and compares on every upd_done.
// Follows TANK_COLLISION_EN in its reference model.
// -----------------------------------------------------------------------------
module tb_tank_move_scheduler;
    import tank_pkg::*;

    localparam int N = 5;
`ifdef TANK_COLLISION_EN
    localparam bit COLL = 1'b1;
`else
    localparam bit COLL = 1'b0;
`endif

    logic clk_25m = 1'b0;
    logic rst_n   = 1'b0;

    tank_move_scheduler_if #(.N_TANK(N)) bus_if ();

    tank_move_scheduler #(.N_TANK(N)) dut (
        .clk_25m (clk_25m),
        .rst_n   (rst_n),
        .bus     (bus_if)
    );

    always #20 clk_25m = ~clk_25m;

    typedef struct packed {
        logic [31:0]      tick_cyc;
        logic [15:0]      lat;
        logic [2*N-1:0]   dir;
        logic [6*N-1:0]   y;
        logic [6*N-1:0]   x;
    } exp_t;

    exp_t exp_q[$];
    int   ovr_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_err    = 0;
    int   m_x[N], m_y[N], m_dir[N];

    always @(posedge clk_25m) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_x[i] = 2 + 12 * i;
            m_y[i] = 22;
            m_dir[i] = 0;
        end
    endtask

    // Reference: serve tanks in index order against current positions.
    task automatic model_frame(input logic [N-1:0] al, input logic [N-1:0] rq,
                               input logic [2*N-1:0] dr, output exp_t e);
        int lat = 1 + N;
        for (int i = 0; i < N; i++) begin
            if (al[i] && rq[i]) begin
                int d  = int'(dr[2*i +: 2]);
                int cx = m_x[i] + ((d == 3) ? 1 : 0) - ((d == 2) ? 1 : 0);
                int cy = m_y[i] + ((d == 1) ? 1 : 0) - ((d == 0) ? 1 : 0);
                m_dir[i] = d;
                if (cx >= 0 && cx <= GRID_W - TANK_SZ && cy >= 0 && cy <= GRID_H - TANK_SZ) begin
                    bit blk = 1'b0;
                    lat += COLL ? (N + 1) : 1;
                    if (COLL)
                        for (int j = 0; j < N; j++)
                            if (j != i && al[j] && iabs(cx - m_x[j]) < TANK_SZ &&
                                iabs(cy - m_y[j]) < TANK_SZ)
                                blk = 1'b1;
                    if (!blk) begin
                        m_x[i] = cx;
                        m_y[i] = cy;
                    end
                end
            end
        end
        e = '0;
        for (int i = 0; i < N; i++) begin
            e.x[6*i +: 6]   = 6'(m_x[i]);
            e.y[6*i +: 6]   = 6'(m_y[i]);
            e.dir[2*i +: 2] = 2'(m_dir[i]);
        end
        e.lat = 16'(lat);
    endtask

    task automatic randomize_inputs();
        bus_if.tank_alive = N'($urandom);
        bus_if.move_req   = N'($urandom);
        bus_if.move_dir   = (2*N)'($urandom);
    endtask

    task automatic issue_tick(input logic [N-1:0] al, input logic [N-1:0] rq,
                              input logic [2*N-1:0] dr, input bit scramble);
        exp_t e;
        @(negedge clk_25m);
        bus_if.tank_alive = al;
        bus_if.move_req   = rq;
        bus_if.move_dir   = dr;
        bus_if.frame_tick = 1'b1;
        model_frame(al, rq, dr, e);
        e.tick_cyc = 32'(cyc);
        exp_q.push_back(e);
        @(negedge clk_25m);
        bus_if.frame_tick = 1'b0;
        if (scramble) randomize_inputs();
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            @(negedge clk_25m);
            k++;
        end
        check({name, " completion"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(negedge clk_25m);
    endtask

    task automatic check_reset_outputs(input string name);
        logic [6*N-1:0] ex, ey;
        for (int i = 0; i < N; i++) begin
            ex[6*i +: 6] = 6'(2 + 12 * i);
            ey[6*i +: 6] = 6'd22;
        end
        check({name, " tank_x"},   64'(bus_if.tank_x),   64'(ex));
        check({name, " tank_y"},   64'(bus_if.tank_y),   64'(ey));
        check({name, " tank_dir"}, 64'(bus_if.tank_dir), 64'd0);
        check({name, " busy"},     64'(bus_if.busy),     64'd0);
        check({name, " upd_done"}, 64'(bus_if.upd_done), 64'd0);
        check({name, " overrun"},  64'(bus_if.overrun),  64'd0);
    endtask

    // Monitor: compares on every status pulse, independent of the stimulus.
    initial begin : monitor
        int   busy_cnt = 0;
        exp_t e;
        forever begin
            @(negedge clk_25m);
            if (!rst_n) begin
                busy_cnt = 0;
            end else begin
                if (bus_if.busy) busy_cnt++;
                if (bus_if.overrun) begin
                    check("overrun expected", 64'(ovr_q.size() != 0), 64'd1);
                    if (ovr_q.size() != 0)
                        check("overrun cycle", 64'(cyc), 64'(ovr_q.pop_front()));
                end
                if (bus_if.upd_done) begin
                    check("upd_done expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("frame tank_x",   64'(bus_if.tank_x),   64'(e.x));
                        check("frame tank_y",   64'(bus_if.tank_y),   64'(e.y));
                        check("frame tank_dir", 64'(bus_if.tank_dir), 64'(e.dir));
                        check("frame latency",  64'(cyc - int'(e.tick_cyc)), 64'(e.lat));
                        check("frame busy cycles", 64'(busy_cnt), 64'(e.lat - 16'd1));
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    initial begin : stimulus
        logic [2*N-1:0] dr;
        bus_if.frame_tick = 1'b0;
        bus_if.tank_alive = '0;
        bus_if.move_req   = '0;
        bus_if.move_dir   = '0;
        model_reset();
        repeat (3) @(negedge clk_25m);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Idle frame: nothing moves, 6-cycle latency.
        issue_tick('1, '0, '0, 1'b0);
        wait_idle("idle frame");

        // Tank 0 steps right.
        dr = '0; dr[1:0] = 2'd3;
        issue_tick('1, N'(1), dr, 1'b1);
        wait_idle("tank0 right");

        // Drive tank 0 to the left wall, then push once more.
        dr = '0; dr[1:0] = 2'd2;
        for (int k = 0; k < 4; k++) begin
            issue_tick('1, N'(1), dr, 1'b1);
            wait_idle("tank0 left");
        end

        // Bring tank 0 to x=11, then tank 1 tries to step into it.
        dr = '0; dr[1:0] = 2'd3;
        for (int k = 0; k < 11; k++) begin
            issue_tick('1, N'(1), dr, 1'b0);
            wait_idle("tank0 approach");
        end
        dr = '0; dr[3:2] = 2'd2;
        issue_tick('1, N'(2), dr, 1'b1);
        wait_idle("tank1 blocked");
        issue_tick(N'(5'b11110), N'(2), dr, 1'b1);
        wait_idle("tank1 dead neighbour");

        // Overrun: second tick 5 cycles after the first, all tanks moving.
        issue_tick('1, '1, (2*N)'($urandom), 1'b0);
        repeat (4) @(negedge clk_25m);
        bus_if.frame_tick = 1'b1;
        ovr_q.push_back(cyc + 1);
        @(negedge clk_25m);
        bus_if.frame_tick = 1'b0;
        wait_idle("overrun frame");
        check("overrun consumed", 64'(ovr_q.size()), 64'd0);

        // Randomized frames with inputs scrambled right after the latch.
        for (int k = 0; k < 40; k++) begin
            logic [N-1:0] al;
            for (int i = 0; i < N; i++) al[i] = ($urandom_range(0, 9) != 0);
            issue_tick(al, N'($urandom), (2*N)'($urandom), 1'b1);
            wait_idle("random frame");
        end

        // Reset in the middle of an update.
        dr = '0; dr[1:0] = 2'd3;
        issue_tick('1, N'(1), dr, 1'b0);
        @(negedge clk_25m);
        #5 rst_n = 1'b0;
        #1 check_reset_outputs("mid-update reset");
        exp_q.delete();
        model_reset();
        @(negedge clk_25m);
        rst_n = 1'b1;
        issue_tick('1, '0, '0, 1'b0);
        wait_idle("post-reset idle frame");

        check("scoreboard drained", 64'(exp_q.size() + ovr_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
